// File: rtl/reg_arith_decoder.sv
// R-type arithmetic decoder (OP, plus OP-32 at XLEN=64, optional M-extension)
// feeding a two-entry skid buffer with a registered in_ready.
package reg_arith_pkg;
    typedef enum logic [4:0] {
        rak_invalid = 5'd0,
        rak_add, rak_sub, rak_sll, rak_slt, rak_sltu, rak_xor, rak_srl, rak_sra,
        rak_or, rak_and,
        rak_mul, rak_mulh, rak_mulhsu, rak_mulhu, rak_div, rak_divu, rak_rem, rak_remu
    } reg_arith_kind_t;

    typedef struct packed {
        reg_arith_kind_t kind;
        logic            word;
        logic            illegal;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
    } rad_entry_t;
endpackage

module reg_arith_decoder
    import reg_arith_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output reg_arith_kind_t out_kind,
    output logic            out_word,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_illegal
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} buf_state_t;

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] OPC_OP32 = 7'b0111011;

    buf_state_t      state_q, state_d;
    rad_entry_t      main_q, main_d;
    rad_entry_t      skid_q, skid_d;
    logic            in_ready_q, in_ready_d;
    rad_entry_t      dec;
    reg_arith_kind_t kind_v;
    logic            is_op, is_w;
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic            in_xfer, out_xfer;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign is_op = (opc == OPC_OP);
    assign is_w  = (XLEN == 64) && (opc == OPC_OP32);

    always_comb begin
        kind_v = rak_invalid;
        if (is_op) begin
            case (f7)
                7'b0000000: begin
                    case (f3)
                        3'd0: kind_v = rak_add;
                        3'd1: kind_v = rak_sll;
                        3'd2: kind_v = rak_slt;
                        3'd3: kind_v = rak_sltu;
                        3'd4: kind_v = rak_xor;
                        3'd5: kind_v = rak_srl;
                        3'd6: kind_v = rak_or;
                        3'd7: kind_v = rak_and;
                    endcase
                end
                7'b0100000: begin
                    if (f3 == 3'd0)      kind_v = rak_sub;
                    else if (f3 == 3'd5) kind_v = rak_sra;
                end
                7'b0000001: begin
                    if (ENABLE_M) begin
                        case (f3)
                            3'd0: kind_v = rak_mul;
                            3'd1: kind_v = rak_mulh;
                            3'd2: kind_v = rak_mulhsu;
                            3'd3: kind_v = rak_mulhu;
                            3'd4: kind_v = rak_div;
                            3'd5: kind_v = rak_divu;
                            3'd6: kind_v = rak_rem;
                            3'd7: kind_v = rak_remu;
                        endcase
                    end
                end
                default: ;
            endcase
        end else if (is_w) begin
            case (f7)
                7'b0000000: begin
                    if (f3 == 3'd0)      kind_v = rak_add;
                    else if (f3 == 3'd1) kind_v = rak_sll;
                    else if (f3 == 3'd5) kind_v = rak_srl;
                end
                7'b0100000: begin
                    if (f3 == 3'd0)      kind_v = rak_sub;
                    else if (f3 == 3'd5) kind_v = rak_sra;
                end
                7'b0000001: begin
                    if (ENABLE_M) begin
                        case (f3)
                            3'd0:    kind_v = rak_mul;
                            3'd4:    kind_v = rak_div;
                            3'd5:    kind_v = rak_divu;
                            3'd6:    kind_v = rak_rem;
                            3'd7:    kind_v = rak_remu;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // word is only reported for a legal W-form op; an illegal word carries no width meaning.
    always_comb begin
        dec         = '0;
        dec.kind    = kind_v;
        dec.illegal = (kind_v == rak_invalid);
        dec.word    = is_w && (kind_v != rak_invalid);
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
    end

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = (state_q != S_EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (in_xfer) begin
                    main_d  = dec;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = dec;
                end else if (in_xfer) begin
                    skid_d  = dec;
                    state_d = S_TWO;
                end else if (out_xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Registered from next state so in_ready never depends on out_ready combinationally.
        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != S_EMPTY);
    assign out_kind    = main_q.kind;
    assign out_word    = main_q.word;
    assign out_illegal = main_q.illegal;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
endmodule

// File: tb/tb_reg_arith_decoder.sv
// Bench for reg_arith_decoder: two configurations (RV64+M, RV32 without M) share
// the same stimulus and are checked against a table-lookup decode model and a FIFO scoreboard.
module tb_reg_arith_decoder;
    import reg_arith_pkg::*;

    logic clk;
    logic rst;
    logic in_valid, out_ready;
    logic [31:0] in_instr;

    logic a_in_ready, a_out_valid, a_word, a_ill;
    reg_arith_kind_t a_kind;
    logic [4:0] a_rd, a_rs1, a_rs2;
    logic b_in_ready, b_out_valid, b_word, b_ill;
    reg_arith_kind_t b_kind;
    logic [4:0] b_rd, b_rs1, b_rs2;
    logic [21:0] a_act, b_act;

    assign a_act = {a_kind, a_word, a_ill, a_rd, a_rs1, a_rs2};
    assign b_act = {b_kind, b_word, b_ill, b_rd, b_rs1, b_rs2};

    reg_arith_decoder #(.XLEN(64), .ENABLE_M(1'b1)) u_d64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_kind(a_kind), .out_word(a_word),
        .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_illegal(a_ill));

    reg_arith_decoder #(.XLEN(32), .ENABLE_M(1'b0)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_kind(b_kind), .out_word(b_word),
        .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_illegal(b_ill));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit              w;
        logic [6:0]      f7;
        logic [2:0]      f3;
        reg_arith_kind_t kind;
        bit              m;
    } legal_t;
    legal_t legal[$];

    function automatic void add_legal(bit w, logic [6:0] f7, logic [2:0] f3, reg_arith_kind_t k, bit m);
        legal_t e;
        e.w = w; e.f7 = f7; e.f3 = f3; e.kind = k; e.m = m;
        legal.push_back(e);
    endfunction

    function automatic void fill_legal();
        reg_arith_kind_t base_k[8];
        reg_arith_kind_t m_k[8];
        base_k = '{rak_add, rak_sll, rak_slt, rak_sltu, rak_xor, rak_srl, rak_or, rak_and};
        m_k    = '{rak_mul, rak_mulh, rak_mulhsu, rak_mulhu, rak_div, rak_divu, rak_rem, rak_remu};
        for (int f = 0; f < 8; f++) begin
            add_legal(1'b0, 7'h00, 3'(f), base_k[f], 1'b0);
            add_legal(1'b0, 7'h01, 3'(f), m_k[f], 1'b1);
        end
        add_legal(1'b0, 7'h20, 3'd0, rak_sub, 1'b0);
        add_legal(1'b0, 7'h20, 3'd5, rak_sra, 1'b0);
        add_legal(1'b1, 7'h00, 3'd0, rak_add, 1'b0);
        add_legal(1'b1, 7'h00, 3'd1, rak_sll, 1'b0);
        add_legal(1'b1, 7'h00, 3'd5, rak_srl, 1'b0);
        add_legal(1'b1, 7'h20, 3'd0, rak_sub, 1'b0);
        add_legal(1'b1, 7'h20, 3'd5, rak_sra, 1'b0);
        add_legal(1'b1, 7'h01, 3'd0, rak_mul, 1'b1);
        add_legal(1'b1, 7'h01, 3'd4, rak_div, 1'b1);
        add_legal(1'b1, 7'h01, 3'd5, rak_divu, 1'b1);
        add_legal(1'b1, 7'h01, 3'd6, rak_rem, 1'b1);
        add_legal(1'b1, 7'h01, 3'd7, rak_remu, 1'b1);
    endfunction

    function automatic logic [21:0] model(logic [31:0] ins, int xlen, bit en_m);
        reg_arith_kind_t k;
        logic wd;
        logic is_w;
        k = rak_invalid;
        wd = 1'b0;
        is_w = (ins[6:0] == 7'h3B);
        if (ins[6:0] == 7'h33 || (is_w && xlen == 64))
            foreach (legal[i])
                if (legal[i].w == is_w && legal[i].f7 == ins[31:25] && legal[i].f3 == ins[14:12]
                    && (!legal[i].m || en_m)) begin
                    k = legal[i].kind;
                    wd = is_w;
                end
        return {k, wd, (k == rak_invalid), ins[11:7], ins[19:15], ins[24:20]};
    endfunction

    // ---------------- checking ----------------
    int n_chk = 0, n_pass = 0;
    logic [31:0] sb[$];
    bit rdy_m = 1'b0;
    bit acc = 1'b0;
    bit prev_stall = 1'b0;
    logic [21:0] prev_a, prev_b;
    int n_out = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Called at the negedge; predicts what the next posedge will transfer.
    task automatic monitor();
        logic [31:0] ins;
        chk("a_in_ready", 32'(a_in_ready), 32'(rdy_m));
        chk("b_in_ready", 32'(b_in_ready), 32'(rdy_m));
        chk("a_out_valid", 32'(a_out_valid), 32'(sb.size() > 0));
        chk("b_out_valid", 32'(b_out_valid), 32'(sb.size() > 0));
        if (prev_stall) begin
            chk("a_stable", 32'(a_act), 32'(prev_a));
            chk("b_stable", 32'(b_act), 32'(prev_b));
        end
        prev_stall = (sb.size() > 0) && !out_ready;
        prev_a = a_act;
        prev_b = b_act;
        if (sb.size() > 0 && out_ready) begin
            ins = sb.pop_front();
            chk("a_entry", 32'(a_act), 32'(model(ins, 64, 1'b1)));
            chk("b_entry", 32'(b_act), 32'(model(ins, 32, 1'b0)));
            n_out++;
        end
        acc = 1'b0;
        if (in_valid && rdy_m) begin
            sb.push_back(in_instr);
            acc = 1'b1;
        end
        rdy_m = !rst && (sb.size() < 2);
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0, 1: r[6:0] = 7'h33;
            2:    r[6:0] = 7'h3B;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    typedef struct {
        logic [31:0]     ins;
        reg_arith_kind_t k64;
        logic            i64;
        logic            w64;
        reg_arith_kind_t k32;
        logic            i32;
    } vec_t;
    vec_t vt[12];
    logic [31:0] bp[4];
    int idx, outs0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
        fill_legal();
        vt[0]  = '{32'h002081B3, rak_add,     1'b0, 1'b0, rak_add,     1'b0};
        vt[1]  = '{32'h407302B3, rak_sub,     1'b0, 1'b0, rak_sub,     1'b0};
        vt[2]  = '{32'h40001033, rak_invalid, 1'b1, 1'b0, rak_invalid, 1'b1};
        vt[3]  = '{32'h023100B3, rak_mul,     1'b0, 1'b0, rak_invalid, 1'b1};
        vt[4]  = '{32'h002081BB, rak_add,     1'b0, 1'b1, rak_invalid, 1'b1};
        vt[5]  = '{32'h0020A1BB, rak_invalid, 1'b1, 1'b0, rak_invalid, 1'b1};
        vt[6]  = '{32'h023110BB, rak_invalid, 1'b1, 1'b0, rak_invalid, 1'b1};
        vt[7]  = '{32'h023150BB, rak_divu,    1'b0, 1'b1, rak_invalid, 1'b1};
        vt[8]  = '{32'h00000013, rak_invalid, 1'b1, 1'b0, rak_invalid, 1'b1};
        vt[9]  = '{32'h4020D1B3, rak_sra,     1'b0, 1'b0, rak_sra,     1'b0};
        vt[10] = '{32'h023170B3, rak_remu,    1'b0, 1'b0, rak_invalid, 1'b1};
        vt[11] = '{32'h0420F1B3, rak_invalid, 1'b1, 1'b0, rak_invalid, 1'b1};

        #1;
        chk("rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_ready", 32'(a_in_ready), 32'd0);
        chk("rst_a_payload", 32'(a_act), 32'd0);
        chk("rst_b_payload", 32'(b_act), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        cycle();

        // Directed decode table, one word at a time.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_instr = vt[i].ins;
            cycle();
            in_valid = 1'b0;
            @(negedge clk);
            chk("vec_k64", 32'(a_kind), 32'(vt[i].k64));
            chk("vec_i64", 32'(a_ill), 32'(vt[i].i64));
            chk("vec_w64", 32'(a_word), 32'(vt[i].w64));
            chk("vec_k32", 32'(b_kind), 32'(vt[i].k32));
            chk("vec_i32", 32'(b_ill), 32'(vt[i].i32));
            chk("vec_w32", 32'(b_word), 32'd0);
            chk("vec_regs", 32'({a_rd, a_rs1, a_rs2}),
                32'({vt[i].ins[11:7], vt[i].ins[19:15], vt[i].ins[24:20]}));
            monitor();
            @(posedge clk); #1;
        end

        // Backpressure: only two words fit, then drain four in four cycles.
        for (int i = 0; i < 4; i++) bp[i] = vt[i].ins;
        out_ready = 1'b0;
        idx = 0;
        repeat (4) begin
            in_valid = (idx < 4);
            in_instr = bp[idx % 4];
            cycle();
            if (acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        out_ready = 1'b1;
        outs0 = n_out;
        repeat (4) begin
            in_valid = (idx < 4);
            in_instr = bp[idx % 4];
            cycle();
            if (acc) idx++;
        end
        chk("bp_drain_4in4", 32'(n_out - outs0), 32'd4);
        chk("bp_all_in", 32'(idx), 32'd4);
        in_valid = 1'b0;
        cycle();

        // Reset while the buffer holds two entries.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_instr = vt[4 + i].ins;
            cycle();
        end
        chk("pre_rst_full", 32'(a_in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("mid_rst_a_ready", 32'(a_in_ready), 32'd0);
        chk("mid_rst_b_valid", 32'(b_out_valid), 32'd0);
        chk("mid_rst_a_payload", 32'(a_act), 32'd0);
        sb.delete();
        rdy_m = 1'b0;
        prev_stall = 1'b0;
        in_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = vt[9].ins;
        outs0 = n_out;
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_first", 32'(a_act), 32'(model(vt[9].ins, 64, 1'b1)));
        monitor();
        @(posedge clk); #1;
        chk("post_rst_one_out", 32'(n_out - outs0), 32'd1);

        // Random traffic against the model.
        repeat (600) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            in_instr  = rand_instr();
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_arith_decoder.md
# reg_arith_decoder

Pipelined, parametrised decoder for register-register (R-type) arithmetic instructions. It accepts full 32-bit instruction words through a valid/ready handshake and decodes the `OP` opcode, plus `OP-32` when `XLEN=64`. Optional M-extension support is controlled by a parameter. Results go into a two-entry skid buffer that drives the execute stage. The block sits between fetch/issue and the ALU/MUL-DIV dispatch. It replaces the single-cycle funct3/funct7-only decoder, adding strict funct7 checking, illegal flagging and backpressure.

## Interface
- `XLEN`, default 32: 32 or 64. At 64, opcode `0111011` (`OP-32`) is accepted and marked `word=1`.
- `ENABLE_M`, default 0: 1 decodes funct7=`0000001` as M-extension ops; 0 flags them illegal.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high. Clock is `clk`.
- `in_valid` in 1: instruction word present.
- `in_ready` out 1: block can accept a word this cycle.
- `in_instr` in 32: raw instruction.
- `out_valid` out 1: decoded entry present.
- `out_ready` in 1: consumer accepts the entry this cycle.
- `out_kind` out `reg_arith_kind_t`: decoded op. The `opcode_type` enum gains `rak_mul`, `rak_mulh`, `rak_mulhsu`, `rak_mulhu`, `rak_div`, `rak_divu`, `rak_rem` and `rak_remu`.
- `out_word` out 1: `OP-32` (W-form) instruction.
- `out_rd`, `out_rs1`, `out_rs2` out 5 each: register fields, bits [11:7], [19:15] and [24:20].
- `out_illegal` out 1: opcode, funct3 or funct7 is not a legal combination. When set, `out_kind=rak_invalid`.

## Operation
- Handshake rules:
  - An input transfer happens when `in_valid && in_ready`.
  - An output transfer happens when `out_valid && out_ready`.
  - `in_valid`/`in_instr` may change freely while `in_ready=0`; nothing is captured.
- Decode is strict. Every legal op requires its exact funct7; any other funct7 is illegal (this also applies to sll, slt, xor and the rest).
  - funct7 `0000000`, by funct3 000..111: add, sll, slt, sltu, xor, srl, or, and.
  - funct7 `0100000`: funct3 000 gives sub, 101 gives sra. Any other funct3 is illegal.
  - funct7 `0000001` with `ENABLE_M=1`, by funct3 000..111: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- `OP-32` decoding (only when `XLEN=64`):
  - Legal ops are add, sub, sll, srl and sra, plus mul, div, divu, rem and remu if `ENABLE_M=1`.
  - Everything else under `OP-32` is illegal. With `XLEN=32` the whole `OP-32` opcode is illegal.
- Any other opcode is illegal.
- Illegal words are still transferred, with `out_illegal=1`. Register fields are always extracted as-is.
- Buffer structure:
  - The main register holds the entry currently driving `out_*`.
  - The skid register captures one extra entry when the main register is full and not draining.
- Buffer states, three in total: EMPTY (0 entries), ONE (main only), TWO (main + skid).
  - EMPTY, input transfer: go to ONE.
  - ONE, input transfer and output transfer in the same cycle: stay in ONE; the main register loads the new entry.
  - ONE, input transfer only: go to TWO; the new entry goes to skid.
  - ONE, output transfer only: go to EMPTY.
  - TWO, output transfer: go to ONE; skid moves to main.
  - No input transfer is possible in TWO.
- Ordering is strictly FIFO. No entry is dropped or duplicated.

## Timing
- Latency: an entry accepted at edge N is presented on `out_*` (`out_valid=1`) immediately after edge N. That is one cycle of latency.
- Throughput: one entry per cycle while `out_ready=1`.
- `in_ready` is a registered output, equal to `state!=TWO`, with no combinational path from `out_ready`. A single cycle of `out_ready=0` therefore costs no throughput.
- Reset, whether asserted asynchronously or mid-stream:
  - Immediately: state=EMPTY, `out_valid=0`, `in_ready=0` while `rst` is high, `out_kind=rak_invalid`, `out_illegal=0`, `out_word=0`, all register fields 0. Entries in flight are discarded.
  - First edge after `rst` falls: `in_ready=1`.
- `out_*` payload is stable while `out_valid && !out_ready`.

## Test plan
- Add: `in_instr=0x002081B3` accepted with `out_ready=1` → next cycle `out_kind=rak_add`, rd=3, rs1=1, rs2=2, `out_illegal=0`, `out_word=0`.
- Sub: `0x407302B3` → `rak_sub`, rd=5, rs1=6, rs2=7.
- Strict funct7 on shifts: `0x40001033` (sll with funct7 `0100000`) → `out_illegal=1`, `rak_invalid`.
- M-extension parameter: `0x023100B3` (mul x1,x2,x3) → `rak_mul` with `ENABLE_M=1`; `out_illegal=1` with `ENABLE_M=0`.
- Backpressure: stream 4 back-to-back words with `out_ready=0` → two are accepted, then `in_ready=0`. Raising `out_ready` drains all 4 in order with no gaps and no duplicates.
- Reset mid-stream: assert `rst` while in state TWO → `out_valid=0` and `in_ready=0` immediately. After release, `in_ready=1` on the next edge, and the first word sent afterwards is the first one output.
